// File: rtl/act_lut_pkg.sv
// Shared constants, sample type and saturation helper for the activation LUT path.
//   DATA_W : signed sample / LUT entry / output width
//   ADDR_W : LUT address width
//   FRAC_W : interpolation fraction width (low bits of the sample)
//   sat_data() clamps a widened sum back to the signed sample range.
package act_lut_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned ADDR_W = 4;
    localparam int unsigned FRAC_W = DATA_W - ADDR_W;

    // diff (DATA_W+1) times zero-extended frac (FRAC_W+1) as a signed product.
    localparam int unsigned PROD_W = DATA_W + FRAC_W + 1;
    // base + (prod >>> FRAC_W) needs two guard bits above the sample width.
    localparam int unsigned SUM_W  = DATA_W + 2;

    typedef logic signed [DATA_W-1:0] sample_t;

    localparam sample_t DATA_MAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam sample_t DATA_MIN = {1'b1, {(DATA_W-1){1'b0}}};

    // The sum fits when every bit from the sample sign bit upwards agrees.
    function automatic sample_t sat_data(input logic signed [SUM_W-1:0] sum);
        sample_t res;
        if (!sum[SUM_W-1] && (sum[SUM_W-2:DATA_W-1] != '0)) begin
            res = DATA_MAX;
        end else if (sum[SUM_W-1] && (sum[SUM_W-2:DATA_W-1] != '1)) begin
            res = DATA_MIN;
        end else begin
            res = sum[DATA_W-1:0];
        end
        return res;
    endfunction

endpackage

// File: rtl/act_lut_interpolator.sv
// Three-stage piecewise-linear interpolator in front of an external combinational LUT.
//   clk, rst            : clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready   : input handshake, in_data is the signed sample
//   lut_address         : upper sample bits from stage 1, to the LUT block
//   lut_base/lut_next   : combinational LUT return for lut_address
//   out_valid/out_ready : output handshake, out_data is the saturated result
//   busy                : any stage holds a valid sample
module act_lut_interpolator
    import act_lut_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] in_data,
    output logic        [ADDR_W-1:0] lut_address,
    input  logic signed [DATA_W-1:0] lut_base,
    input  logic signed [DATA_W-1:0] lut_next,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [DATA_W-1:0] out_data,
    output logic                     busy
);

    // Stage 1: raw sample
    sample_t s1_x_q, s1_x_d;
    logic    s1_v_q, s1_v_d;

    // Stage 2: LUT operands and fraction
    sample_t                   base_q, base_d;
    logic signed [DATA_W:0]    diff_q, diff_d;
    logic        [FRAC_W-1:0]  frac_q, frac_d;
    logic                      s2_v_q, s2_v_d;

    // Stage 3: result
    sample_t out_q, out_d;
    logic    out_v_q, out_v_d;

    logic                     stall;
    logic signed [PROD_W-1:0] diff_ext;
    logic signed [PROD_W-1:0] frac_ext;
    logic signed [PROD_W-1:0] prod;
    logic signed [PROD_W-1:0] prod_shr;
    logic signed [SUM_W-1:0]  sum;

    always_comb begin
        stall    = out_v_q & ~out_ready;

        diff_ext = {{(PROD_W-DATA_W-1){diff_q[DATA_W]}}, diff_q};
        frac_ext = $signed({{(PROD_W-FRAC_W){1'b0}}, frac_q});
        prod     = diff_ext * frac_ext;
        // Arithmetic shift floors toward -inf; no rounding term by design.
        prod_shr = prod >>> FRAC_W;
        sum      = {{(SUM_W-DATA_W){base_q[DATA_W-1]}}, base_q} + prod_shr[SUM_W-1:0];

        s1_x_d  = s1_x_q;
        s1_v_d  = s1_v_q;
        base_d  = base_q;
        diff_d  = diff_q;
        frac_d  = frac_q;
        s2_v_d  = s2_v_q;
        out_d   = out_q;
        out_v_d = out_v_q;

        // One shared enable: the whole pipe advances or the whole pipe holds.
        if (!stall) begin
            s1_x_d  = in_data;
            s1_v_d  = in_valid;
            base_d  = lut_base;
            diff_d  = {lut_next[DATA_W-1], lut_next} - {lut_base[DATA_W-1], lut_base};
            frac_d  = s1_x_q[FRAC_W-1:0];
            s2_v_d  = s1_v_q;
            out_d   = sat_data(sum);
            out_v_d = s2_v_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_x_q  <= '0;
            s1_v_q  <= 1'b0;
            base_q  <= '0;
            diff_q  <= '0;
            frac_q  <= '0;
            s2_v_q  <= 1'b0;
            out_q   <= '0;
            out_v_q <= 1'b0;
        end else begin
            s1_x_q  <= s1_x_d;
            s1_v_q  <= s1_v_d;
            base_q  <= base_d;
            diff_q  <= diff_d;
            frac_q  <= frac_d;
            s2_v_q  <= s2_v_d;
            out_q   <= out_d;
            out_v_q <= out_v_d;
        end
    end

    assign in_ready    = ~stall;
    assign lut_address = s1_x_q[DATA_W-1:FRAC_W];
    assign out_valid   = out_v_q;
    assign out_data    = out_q;
    assign busy        = s1_v_q | s2_v_q | out_v_q;

endmodule

// File: tb/tb_act_lut_interpolator.sv
// Self-checking bench for act_lut_interpolator with a behavioural LUT and scoreboard.
module tb_act_lut_interpolator;

    logic              clk;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic signed [7:0] in_data;
    logic        [3:0] lut_address;
    logic signed [7:0] lut_base;
    logic signed [7:0] lut_next;
    logic              out_valid;
    logic              out_ready;
    logic signed [7:0] out_data;
    logic              busy;

    int n_pass  = 0;
    int n_total = 0;

    logic signed [7:0] lut [16];
    int exp_q[$];

    act_lut_interpolator dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .lut_address (lut_address),
        .lut_base    (lut_base),
        .lut_next    (lut_next),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // LUT block stand-in: last entry wraps to entry 0, positive endpoint repeats itself.
    always_comb begin
        lut_base = lut[lut_address];
        if (lut_address == 4'd7) lut_next = lut[7];
        else                     lut_next = lut[lut_address + 4'd1];
    end

    task automatic check(input string name, input int actual, input int expected);
        n_total++;
        if (actual == expected) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    endtask

    // Reference: linear interpolation with floor division, then clamp to int8.
    function automatic int model(input logic [7:0] x);
        int a, f, b, n, p, q, s;
        a = int'(x[7:4]);
        f = int'(x[3:0]);
        b = int'(lut[a]);
        n = (a == 7) ? int'(lut[7]) : int'(lut[(a + 1) % 16]);
        p = (n - b) * f;
        q = (p >= 0) ? p / 16 : -((-p + 15) / 16);
        s = b + q;
        if (s > 127)  s = 127;
        if (s < -128) s = -128;
        return s;
    endfunction

    // Scoreboard: evaluated at the falling edge, i.e. the state the next rising edge sees.
    always @(negedge clk) begin
        if (!rst) begin
            exp_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_total++;
                    $display("FAIL sb_extra: got unexpected out_data %0d, expected no result at %0t",
                             out_data, $time);
                end else begin
                    check("sb_order", int'(out_data), exp_q.pop_front());
                end
            end
            if (in_valid && in_ready) exp_q.push_back(model(in_data));
        end
    end

    // One sample into an idle pipe, with exact latency checks.
    task automatic send_one(input logic [7:0] din, input int exp_out, input int exp_addr);
        @(posedge clk) #1;
        in_valid = 1'b1;
        in_data  = din;
        @(posedge clk) #1;
        in_valid = 1'b0;
        check("lat_addr", int'(lut_address), exp_addr);
        check("lat_v1", int'(out_valid), 0);
        @(posedge clk) #1;
        check("lat_v2", int'(out_valid), 0);
        @(posedge clk) #1;
        check("lat_v3", int'(out_valid), 1);
        check("lat_data", int'(out_data), exp_out);
    endtask

    task automatic drain(input string name);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
        @(posedge clk) #1;
        check(name, exp_q.size(), 0);
    endtask

    typedef struct {
        logic [7:0] din;
        int         exp_out;
        int         exp_addr;
    } vec_t;

    vec_t vecs[7];
    logic signed [7:0] held_data;
    logic        [3:0] held_addr;

    initial begin
        vecs[0] = '{din: 8'h08, exp_out: 6,   exp_addr: 0};
        vecs[1] = '{din: 8'h18, exp_out: 13,  exp_addr: 1};
        vecs[2] = '{din: 8'hF8, exp_out: -6,  exp_addr: 15};
        vecs[3] = '{din: 8'h78, exp_out: 15,  exp_addr: 7};
        vecs[4] = '{din: 8'h88, exp_out: -15, exp_addr: 8};
        vecs[5] = '{din: 8'hF1, exp_out: -12, exp_addr: 15};
        vecs[6] = '{din: 8'h01, exp_out: 0,   exp_addr: 0};

        lut[0]  = 0;   lut[1]  = 12;  lut[2]  = 15;  lut[3]  = 15;
        lut[4]  = 15;  lut[5]  = 15;  lut[6]  = 15;  lut[7]  = 15;
        lut[8]  = -15; lut[9]  = -15; lut[10] = -15; lut[11] = -15;
        lut[12] = -15; lut[13] = -15; lut[14] = -15; lut[15] = -12;

        rst       = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;

        #12;
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_data", int'(out_data), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_lut_addr", int'(lut_address), 0);
        check("rst_in_ready", int'(in_ready), 1);
        @(posedge clk) #1;
        rst = 1'b1;

        // Directed vectors
        foreach (vecs[i]) send_one(vecs[i].din, vecs[i].exp_out, vecs[i].exp_addr);

        // Streaming: 16 back-to-back samples on entry boundaries
        for (int k = 0; k < 20; k++) begin
            @(posedge clk) #1;
            if (k >= 3 && k < 19) begin
                check("stream_valid", int'(out_valid), 1);
                check("stream_data", int'(out_data), int'(lut[k - 3]));
            end
            if (k == 19) check("stream_tail", int'(out_valid), 0);
            in_valid = (k < 16);
            in_data  = 8'(k * 16);
        end
        drain("stream_drain");

        // Back-pressure with a full pipe
        for (int k = 0; k < 3; k++) begin
            @(posedge clk) #1;
            in_valid = 1'b1;
            in_data  = 8'(8'h08 + k * 16);
        end
        @(posedge clk) #1;
        in_data   = 8'h48;
        out_ready = 1'b0;
        #1;
        held_data = out_data;
        held_addr = lut_address;
        check("bp_full", int'(out_valid), 1);
        check("bp_first", int'(held_data), 6);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk) #1;
            check("bp_in_ready", int'(in_ready), 0);
            check("bp_out_valid", int'(out_valid), 1);
            check("bp_data_hold", int'(out_data), int'(held_data));
            check("bp_addr_hold", int'(lut_address), int'(held_addr));
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_ready", int'(in_ready), 1);
        @(posedge clk) #1;
        in_valid = 1'b0;
        drain("bp_drain");

        // Reset with three samples in flight
        for (int k = 0; k < 3; k++) begin
            @(posedge clk) #1;
            in_valid = 1'b1;
            in_data  = 8'(8'h18 + k * 16);
        end
        @(posedge clk) #1;
        in_valid = 1'b0;
        rst      = 1'b0;
        #1;
        check("mrst_out_valid", int'(out_valid), 0);
        check("mrst_busy", int'(busy), 0);
        check("mrst_lut_addr", int'(lut_address), 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk) #1;
            check("mrst_no_stale", int'(out_valid), 0);
        end
        send_one(8'h18, 13, 1);
        drain("mrst_drain");

        // Randomized traffic against the reference model with a random table
        foreach (lut[i]) lut[i] = 8'($urandom);
        for (int k = 0; k < 400; k++) begin
            @(posedge clk) #1;
            in_valid  = ($urandom_range(0, 9) < 7);
            in_data   = 8'($urandom);
            out_ready = ($urandom_range(0, 9) < 7);
        end
        drain("rand_drain");
        check("rand_idle", int'(busy), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
